// File: rtl/hamming_pkg.sv
// Shared definitions for the SEC/DED (7,4)+parity link: receiver states,
// syndrome masks and the syndrome helper used by encoder, decoder and receiver.
package hamming_pkg;

  typedef enum logic [2:0] {
    REPOSO      = 3'd0,
    INICIO      = 3'd1,
    DATOS       = 3'd2,
    PARADA      = 3'd3,
    DECODIFICA  = 3'd4,
    ESPERA_ALTO = 3'd5
  } estado_rx_t;

  // palabra[i-1] carries Hamming position i; masks select the positions each check covers
  localparam logic [7:0] MASCARA_S1 = 8'h55;  // positions 1,3,5,7
  localparam logic [7:0] MASCARA_S2 = 8'h66;  // positions 2,3,6,7
  localparam logic [7:0] MASCARA_S3 = 8'h78;  // positions 4,5,6,7

  // Data positions d4,d3,d2,d1 packed 3 bits each, d1 in the low field
  localparam logic [11:0] POS_DATOS = {3'd7, 3'd6, 3'd5, 3'd3};

  function automatic logic [2:0] sindrome_de(input logic [7:0] palabra);
    return {^(palabra & MASCARA_S3), ^(palabra & MASCARA_S2), ^(palabra & MASCARA_S1)};
  endfunction

endpackage

// File: rtl/corrector_secded.sv
// Combinational SEC/DED decoder: syndrome, overall parity, single-error
// correction of the data positions and error classification.
module corrector_secded
  import hamming_pkg::*;
(
  input  logic [7:0] palabra,
  output logic [3:0] dato,
  output logic [2:0] sindrome,
  output logic       st,
  output logic       error_simple,
  output logic       error_doble
);

  logic [2:0] sind;
  logic       paridad;

  assign sind    = sindrome_de(palabra);
  assign paridad = ^palabra;

  // A data bit is flipped only when the parity confirms an odd error count
  // and the syndrome points at that data position.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dato
      localparam logic [2:0] POS = POS_DATOS[gi*3 +: 3];
      localparam int         IDX = int'(POS) - 1;
      assign dato[gi] = palabra[IDX] ^ (paridad && (sind == POS));
    end
  endgenerate

  assign sindrome     = sind;
  assign st           = paridad;
  assign error_simple = paridad;
  assign error_doble  = !paridad && (sind != 3'b000);

endmodule

// File: rtl/receptor_hamming_serial.sv
// UART-style receiver for 8-bit SEC/DED codewords: 2-flop synchronizer,
// bit-timing counters, framing FSM and held decoded outputs.
module receptor_hamming_serial
  import hamming_pkg::*;
#(
  parameter int CICLOS_BIT = 16
) (
  input  logic       reloj,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] dato,
  output logic [7:0] palabra_rx,
  output logic [2:0] sindrome,
  output logic       st,
  output logic       error_simple,
  output logic       error_doble,
  output logic       valido,
  output logic       error_trama,
  output logic       ocupado
);

  localparam int              CW           = $clog2(CICLOS_BIT);
  localparam logic [CW-1:0]   CUENTA_MEDIO = CW'(CICLOS_BIT / 2 - 1);
  localparam logic [CW-1:0]   CUENTA_BIT   = CW'(CICLOS_BIT - 1);

  estado_rx_t    estado_q, estado_d;
  logic          sinc1_q, sinc1_d, sinc2_q, sinc2_d;
  logic [CW-1:0] cuenta_q, cuenta_d;
  logic [2:0]    nbit_q, nbit_d;
  logic [7:0]    desplaza_q, desplaza_d;
  logic [3:0]    dato_q, dato_d;
  logic [7:0]    palabra_q, palabra_d;
  logic [2:0]    sindrome_q, sindrome_d;
  logic          st_q, st_d;
  logic          es_q, es_d;
  logic          ed_q, ed_d;
  logic          valido_q, valido_d;
  logic          trama_q, trama_d;

  logic          rx_s;
  logic [3:0]    c_dato;
  logic [2:0]    c_sind;
  logic          c_st, c_es, c_ed;

  assign rx_s = sinc2_q;

  corrector_secded u_corrector (
    .palabra      (desplaza_q),
    .dato         (c_dato),
    .sindrome     (c_sind),
    .st           (c_st),
    .error_simple (c_es),
    .error_doble  (c_ed)
  );

  always_comb begin
    estado_d   = estado_q;
    sinc1_d    = rx;
    sinc2_d    = sinc1_q;
    cuenta_d   = cuenta_q;
    nbit_d     = nbit_q;
    desplaza_d = desplaza_q;
    dato_d     = dato_q;
    palabra_d  = palabra_q;
    sindrome_d = sindrome_q;
    st_d       = st_q;
    es_d       = es_q;
    ed_d       = ed_q;
    valido_d   = 1'b0;
    trama_d    = 1'b0;

    unique case (estado_q)
      REPOSO: begin
        if (!rx_s) begin
          estado_d = INICIO;
          cuenta_d = '0;
        end
      end

      INICIO: begin
        if (cuenta_q == CUENTA_MEDIO) begin
          cuenta_d = '0;
          if (rx_s) begin
            estado_d = REPOSO;
          end else begin
            estado_d = DATOS;
            nbit_d   = 3'd0;
          end
        end else begin
          cuenta_d = cuenta_q + 1'b1;
        end
      end

      DATOS: begin
        if (cuenta_q == CUENTA_BIT) begin
          cuenta_d   = '0;
          desplaza_d = {rx_s, desplaza_q[7:1]};
          nbit_d     = nbit_q + 3'd1;
          if (nbit_q == 3'd7) estado_d = PARADA;
        end else begin
          cuenta_d = cuenta_q + 1'b1;
        end
      end

      PARADA: begin
        if (cuenta_q == CUENTA_BIT) begin
          cuenta_d = '0;
          if (rx_s) begin
            // Results are loaded on the stop-sample edge so they are already
            // stable during the DECODIFICA cycle in which valido is high.
            estado_d   = DECODIFICA;
            dato_d     = c_dato;
            palabra_d  = desplaza_q;
            sindrome_d = c_sind;
            st_d       = c_st;
            es_d       = c_es;
            ed_d       = c_ed;
            valido_d   = 1'b1;
          end else begin
            estado_d = ESPERA_ALTO;
            trama_d  = 1'b1;
          end
        end else begin
          cuenta_d = cuenta_q + 1'b1;
        end
      end

      DECODIFICA: estado_d = REPOSO;

      ESPERA_ALTO: begin
        if (rx_s) estado_d = REPOSO;
      end

      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (rst) begin
      estado_q   <= REPOSO;
      sinc1_q    <= 1'b1;
      sinc2_q    <= 1'b1;
      cuenta_q   <= '0;
      nbit_q     <= 3'd0;
      desplaza_q <= 8'h00;
      dato_q     <= 4'h0;
      palabra_q  <= 8'h00;
      sindrome_q <= 3'b000;
      st_q       <= 1'b0;
      es_q       <= 1'b0;
      ed_q       <= 1'b0;
      valido_q   <= 1'b0;
      trama_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      sinc1_q    <= sinc1_d;
      sinc2_q    <= sinc2_d;
      cuenta_q   <= cuenta_d;
      nbit_q     <= nbit_d;
      desplaza_q <= desplaza_d;
      dato_q     <= dato_d;
      palabra_q  <= palabra_d;
      sindrome_q <= sindrome_d;
      st_q       <= st_d;
      es_q       <= es_d;
      ed_q       <= ed_d;
      valido_q   <= valido_d;
      trama_q    <= trama_d;
    end
  end

  assign dato         = dato_q;
  assign palabra_rx   = palabra_q;
  assign sindrome     = sindrome_q;
  assign st           = st_q;
  assign error_simple = es_q;
  assign error_doble  = ed_q;
  assign valido       = valido_q;
  assign error_trama  = trama_q;
  assign ocupado      = (estado_q != REPOSO);

endmodule

// File: tb/tb_receptor_hamming_serial.sv
// Scoreboard bench for receptor_hamming_serial: frames are serialized on rx,
// expected results queued at send time and checked when valido/error_trama fire.
module tb_receptor_hamming_serial;

  localparam int N = 16;
  localparam int H = N / 2;

  logic       reloj = 1'b0;
  logic       rst;
  logic       rx;
  logic [3:0] dato;
  logic [7:0] palabra_rx;
  logic [2:0] sindrome;
  logic       st, error_simple, error_doble, valido, error_trama, ocupado;

  always #5 reloj = ~reloj;

  receptor_hamming_serial #(.CICLOS_BIT(N)) dut (
    .reloj        (reloj),
    .rst          (rst),
    .rx           (rx),
    .dato         (dato),
    .palabra_rx   (palabra_rx),
    .sindrome     (sindrome),
    .st           (st),
    .error_simple (error_simple),
    .error_doble  (error_doble),
    .valido       (valido),
    .error_trama  (error_trama),
    .ocupado      (ocupado)
  );

  typedef struct {
    logic       trama;
    int         ciclo;
    logic [7:0] palabra;
    logic [3:0] dato;
    logic [2:0] sind;
    logic       st;
    logic       es;
    logic       ed;
  } esperado_t;

  esperado_t sb[$];
  esperado_t ultimo;
  esperado_t e_mon;
  int        n_cmp = 0;
  int        n_err = 0;
  int        cyc = 0;
  logic      valido_prev = 1'b0;

  always @(posedge reloj) cyc <= cyc + 1;

  task automatic chk(input string nombre, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nombre, act, req, cyc);
    end
  endtask

  function automatic esperado_t cero();
    esperado_t e;
    e.trama = 1'b0; e.ciclo = 0; e.palabra = 8'h00; e.dato = 4'h0;
    e.sind = 3'b000; e.st = 1'b0; e.es = 1'b0; e.ed = 1'b0;
    return e;
  endfunction

  // Reference: syndrome is the XOR of the indices of all set positions 1..7.
  function automatic esperado_t modelo(input logic [7:0] w);
    esperado_t e;
    int s = 0;
    int unos = 0;
    logic [7:0] c;
    for (int i = 1; i <= 7; i++) if (w[i-1]) s = s ^ i;
    for (int i = 0; i < 8; i++) if (w[i]) unos++;
    e = cero();
    e.palabra = w;
    e.st = ((unos % 2) == 1);
    c = w;
    if (e.st && s != 0) c[s-1] = ~c[s-1];
    e.dato = {c[6], c[5], c[4], c[2]};
    e.sind = 3'(s);
    e.es = e.st;
    e.ed = !e.st && (s != 0);
    return e;
  endfunction

  function automatic esperado_t fijo(input logic [7:0] w, input logic [3:0] d, input logic [2:0] s,
                                     input logic t, input logic es, input logic ed);
    esperado_t e;
    e = cero();
    e.palabra = w; e.dato = d; e.sind = s; e.st = t; e.es = es; e.ed = ed;
    return e;
  endfunction

  // Must be called right after a falling clock edge; drives a complete 10-bit frame.
  task automatic enviar(input logic [7:0] w, input logic parada, input bit usar_fijo,
                        input esperado_t e_fijo);
    esperado_t e;
    int c0;
    c0 = cyc;
    if (parada) begin
      e = usar_fijo ? e_fijo : modelo(w);
      ultimo = e;
    end else begin
      e = ultimo;
      e.trama = 1'b1;
    end
    e.ciclo = c0 + 3 + H + 9 * N;
    sb.push_back(e);
    $display("send palabra=%02h stop=%0b expect dato=%b sind=%b st=%0b es=%0b ed=%0b trama=%0b",
             w, parada, e.dato, e.sind, e.st, e.es, e.ed, e.trama);
    rx = 1'b0;
    repeat (N) @(negedge reloj);
    for (int k = 0; k < 8; k++) begin
      rx = w[k];
      repeat (N) @(negedge reloj);
    end
    rx = parada;
    repeat (N) @(negedge reloj);
  endtask

  task automatic chk_salidas_cero(input string etiqueta);
    chk({etiqueta, "_dato"}, 32'(dato), 0);
    chk({etiqueta, "_palabra_rx"}, 32'(palabra_rx), 0);
    chk({etiqueta, "_flags"}, 32'({sindrome, st, error_simple, error_doble, valido, error_trama}), 0);
    chk({etiqueta, "_ocupado"}, 32'(ocupado), 0);
  endtask

  // Monitor: pops one expectation per valido / error_trama pulse.
  always @(negedge reloj) begin
    if (!rst) begin
      if (valido || error_trama) begin
        chk("valido_y_trama_exclusivos", 32'(valido & error_trama), 0);
        if (sb.size() == 0) begin
          chk("salida_inesperada", 32'({valido, error_trama}), 0);
        end else begin
          e_mon = sb.pop_front();
          chk("tipo_pulso_trama", 32'(error_trama), 32'(e_mon.trama));
          chk("ciclo_pulso", cyc, e_mon.ciclo);
          chk("dato", 32'(dato), 32'(e_mon.dato));
          chk("palabra_rx", 32'(palabra_rx), 32'(e_mon.palabra));
          chk("sindrome", 32'(sindrome), 32'(e_mon.sind));
          chk("st", 32'(st), 32'(e_mon.st));
          chk("error_simple", 32'(error_simple), 32'(e_mon.es));
          chk("error_doble", 32'(error_doble), 32'(e_mon.ed));
          $display("recv valido=%0b trama=%0b palabra_rx=%02h dato=%b sind=%b st=%0b es=%0b ed=%0b",
                   valido, error_trama, palabra_rx, dato, sindrome, st, error_simple, error_doble);
        end
      end
      if (valido) chk("valido_un_ciclo", 32'(valido_prev), 0);
    end
    valido_prev = valido;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    ultimo = cero();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge reloj);
    chk_salidas_cero("reset");
    rst = 1'b0;
    repeat (5) @(negedge reloj);

    enviar(8'hD2, 1'b1, 1'b1, fijo(8'hD2, 4'b1010, 3'b000, 1'b0, 1'b0, 1'b0));
    repeat (7) @(negedge reloj);
    enviar(8'hC2, 1'b1, 1'b1, fijo(8'hC2, 4'b1010, 3'b101, 1'b1, 1'b1, 1'b0));
    repeat (7) @(negedge reloj);
    enviar(8'hD1, 1'b1, 1'b1, fijo(8'hD1, 4'b1010, 3'b011, 1'b0, 1'b0, 1'b1));
    repeat (7) @(negedge reloj);
    enviar(8'h52, 1'b1, 1'b1, fijo(8'h52, 4'b1010, 3'b000, 1'b1, 1'b1, 1'b0));
    repeat (7) @(negedge reloj);

    // Missing stop bit: line stays low, receiver must wait for it to go high
    enviar(8'hA5, 1'b0, 1'b0, ultimo);
    repeat (2 * N) @(negedge reloj);
    chk("espera_alto_ocupado", 32'(ocupado), 1);
    rx = 1'b1;
    repeat (4) @(negedge reloj);
    chk("tras_trama_ocupado", 32'(ocupado), 0);
    chk("tras_trama_dato_retenido", 32'(dato), 32'(ultimo.dato));
    chk("tras_trama_palabra_retenida", 32'(palabra_rx), 32'(ultimo.palabra));

    // Short glitch on idle line
    rx = 1'b0;
    repeat (3) @(negedge reloj);
    rx = 1'b1;
    repeat (3) @(negedge reloj);
    chk("glitch_ocupado_alto", 32'(ocupado), 1);
    repeat (2 * N) @(negedge reloj);
    chk("glitch_ocupado_bajo", 32'(ocupado), 0);
    chk("glitch_dato_retenido", 32'(dato), 32'(ultimo.dato));

    // Back-to-back frames, single stop bit
    enviar(8'hD2, 1'b1, 1'b1, fijo(8'hD2, 4'b1010, 3'b000, 1'b0, 1'b0, 1'b0));
    enviar(8'hC2, 1'b1, 1'b1, fijo(8'hC2, 4'b1010, 3'b101, 1'b1, 1'b1, 1'b0));
    repeat (5) @(negedge reloj);

    // Reset in the middle of the data bits
    rx = 1'b0;
    repeat (N) @(negedge reloj);
    for (int k = 0; k < 3; k++) begin
      rx = k[0];
      repeat (N) @(negedge reloj);
    end
    chk("datos_ocupado", 32'(ocupado), 1);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge reloj);
    chk_salidas_cero("reset_en_datos");
    ultimo = cero();
    rst = 1'b0;
    repeat (5) @(negedge reloj);
    enviar(8'hD2, 1'b1, 1'b1, fijo(8'hD2, 4'b1010, 3'b000, 1'b0, 1'b0, 1'b0));
    repeat (3) @(negedge reloj);

    // Random received words, random idle gaps including zero
    for (int i = 0; i < 24; i++) begin
      w = 8'($urandom_range(0, 255));
      enviar(w, 1'b1, 1'b0, ultimo);
      repeat ($urandom_range(0, 4)) @(negedge reloj);
    end

    repeat (2 * N) @(negedge reloj);
    chk("cola_vacia", sb.size(), 0);
    chk("final_ocupado", 32'(ocupado), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
